// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit controller: access sizes,
// FSM states and the alignment legality rule.
package lsu_ctrl_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_X = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Naturally aligned accesses only; the reserved size never reaches memory.
    function automatic logic access_ok(input size_e size, input logic [1:0] off);
        case (size)
            SZ_B:    access_ok = 1'b1;
            SZ_H:    access_ok = ~off[0];
            SZ_W:    access_ok = (off == 2'b00);
            default: access_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data/mask placement into the 32-bit word and
// load data extraction with sign or zero extension.
module lsu_align
    import lsu_ctrl_pkg::*;
(
    input  logic [1:0]  st_off_i,
    input  size_e       st_size_i,
    input  logic [31:0] st_wdata_i,
    output logic [31:0] st_wdata_o,
    output logic [7:0]  st_wmask_o,
    input  logic [1:0]  ld_off_i,
    input  size_e       ld_size_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [3:0]  lane_mask;
    logic [3:0]  base_mask;
    logic [31:0] ld_shifted;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        base_mask  = 4'b0000;
        ld_data_o  = 32'd0;
        st_wdata_o = st_wdata_i << {st_off_i, 3'b000};

        case (st_size_i)
            SZ_B:    base_mask = 4'b0001;
            SZ_H:    base_mask = 4'b0011;
            SZ_W:    base_mask = 4'b1111;
            default: base_mask = 4'b0000;
        endcase
        lane_mask  = base_mask << st_off_i;
        st_wmask_o = {4'b0000, lane_mask};

        ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};
        case (ld_size_i)
            SZ_B:    ld_data_o = {{24{~ld_unsigned_i & ld_shifted[7]}},  ld_shifted[7:0]};
            SZ_H:    ld_data_o = {{16{~ld_unsigned_i & ld_shifted[15]}}, ld_shifted[15:0]};
            SZ_W:    ld_data_o = ld_shifted;
            default: ld_data_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one request at a time, performs a single
// one-cycle memory access (or rejects it as misaligned) and holds the response.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        in_wen_i,
    input  logic [31:0] in_addr_i,
    input  logic [31:0] in_wdata_i,
    input  logic [1:0]  in_size_i,
    input  logic        in_unsigned_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_rdata_o,
    output logic        out_err_o,
    output logic        mem_valid_o,
    output logic        mem_wen_o,
    output logic [31:0] mem_raddr_o,
    output logic [31:0] mem_waddr_o,
    output logic [31:0] mem_wdata_o,
    output logic [7:0]  mem_wmask_o,
    input  logic [31:0] mem_rdata_i
);

    state_e      state_q;
    logic [31:0] addr_q;
    logic [1:0]  off_q;
    size_e       size_q;
    logic        unsigned_q;
    logic        mem_valid_q;
    logic        mem_wen_q;
    logic [31:0] mem_wdata_q;
    logic [7:0]  mem_wmask_q;
    logic        out_valid_q;
    logic        out_err_q;
    logic [31:0] out_rdata_q;

    size_e       in_size;
    logic [31:0] st_wdata;
    logic [7:0]  st_wmask;
    logic [31:0] ld_data;

    assign in_size = size_e'(in_size_i);

    lsu_align u_align (
        .st_off_i      (in_addr_i[1:0]),
        .st_size_i     (in_size),
        .st_wdata_i    (in_wdata_i),
        .st_wdata_o    (st_wdata),
        .st_wmask_o    (st_wmask),
        .ld_off_i      (off_q),
        .ld_size_i     (size_q),
        .ld_unsigned_i (unsigned_q),
        .ld_rdata_i    (mem_rdata_i),
        .ld_data_o     (ld_data)
    );

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= 32'd0;
            off_q       <= 2'd0;
            size_q      <= SZ_B;
            unsigned_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_wdata_q <= 32'd0;
            mem_wmask_q <= 8'd0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_rdata_q <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        addr_q     <= {in_addr_i[31:2], 2'b00};
                        off_q      <= in_addr_i[1:0];
                        size_q     <= in_size;
                        unsigned_q <= in_unsigned_i;
                        if (access_ok(in_size, in_addr_i[1:0])) begin
                            state_q     <= ST_ACCESS;
                            mem_valid_q <= 1'b1;
                            mem_wen_q   <= in_wen_i;
                            mem_wdata_q <= st_wdata;
                            mem_wmask_q <= in_wen_i ? st_wmask : 8'd0;
                        end else begin
                            state_q     <= ST_RESP;
                            out_valid_q <= 1'b1;
                            out_err_q   <= 1'b1;
                            out_rdata_q <= 32'd0;
                        end
                    end
                end
                ST_ACCESS: begin
                    // Memory strobes last exactly this one cycle.
                    mem_valid_q <= 1'b0;
                    mem_wen_q   <= 1'b0;
                    mem_wmask_q <= 8'd0;
                    out_valid_q <= 1'b1;
                    out_err_q   <= 1'b0;
                    out_rdata_q <= mem_wen_q ? 32'd0 : ld_data;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        out_err_q   <= 1'b0;
                        out_rdata_q <= 32'd0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = out_valid_q;
    assign out_err_o   = out_err_q;
    assign out_rdata_o = out_rdata_q;
    assign mem_valid_o = mem_valid_q;
    assign mem_wen_o   = mem_wen_q;
    assign mem_raddr_o = addr_q;
    assign mem_waddr_o = addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wmask_o = mem_wmask_q;

endmodule
